clz_divider: RTL and testbench

//  Multi-cycle 32-bit DIV/DIVU unit for the CPU execute stage; consumes the leading-zero count of the

---
 rtl/clz_divider_pkg.sv | 18 +
 rtl/clz_divider_clz.sv | 17 +
 rtl/clz_divider.sv | 167 ++++++++++++++++
 tb/tb_clz_divider.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/clz_divider_pkg.sv
// Shared types and constants for the leading-zero-skipping divider.
package clz_divider_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 6;
   localparam int unsigned LZ_W   = 6;

   localparam logic [DATA_W-1:0] DBZ_QUOT_DEF = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PREP = 3'd1,
      ST_ITER = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

endpackage : clz_divider_pkg

// File: rtl/clz_divider_clz.sv
// 32-bit count-leading-zeros; returns 32 for an all-zero input.
module clz_divider_clz
   import clz_divider_pkg::*;
(
   input  logic [DATA_W-1:0] val_i,
   output logic [LZ_W-1:0]   lz_o
);

   // Highest set bit wins because the scan runs upward and overwrites.
   always_comb begin
      lz_o = LZ_W'(32);
      for (int i = 0; i < 32; i++) begin
         if (val_i[i]) lz_o = LZ_W'(31 - i);
      end
   end

endmodule : clz_divider_clz

// File: rtl/clz_divider.sv
// Multi-cycle DIV/DIVU unit: restoring divide, one bit per cycle, starting
// at the first significant dividend bit so latency tracks operand size.
module clz_divider
   import clz_divider_pkg::*;
#(
   parameter logic [DATA_W-1:0] DBZ_QUOT = DBZ_QUOT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              is_signed,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder,
   output logic              busy,
   output logic              done
);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   a_mag_q, a_mag_d;
   logic [DATA_W-1:0]   b_mag_q, b_mag_d;
   logic [DATA_W-1:0]   dvd_q, dvd_d;
   logic                sa_q, sa_d;
   logic                sb_q, sb_d;
   logic                dbz_q, dbz_d;
   logic [DATA_W-1:0]   d_q, d_d;
   logic [DATA_W-1:0]   r_q, r_d;
   logic [DATA_W-1:0]   q_q, q_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   quot_q, quot_d;
   logic [DATA_W-1:0]   rem_q, rem_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [LZ_W-1:0]     lz_c;
   logic [DATA_W:0]     t_c;
   logic                ge_c;
   logic                sa_in_c;
   logic                sb_in_c;

   clz_divider_clz u_clz (
      .val_i (a_mag_q),
      .lz_o  (lz_c)
   );

   // Trial value for one restoring step: partial remainder shifted left with the next dividend bit.
   assign t_c     = {r_q, d_q[DATA_W-1]};
   assign ge_c    = (t_c >= {1'b0, b_mag_q});
   assign sa_in_c = is_signed & dividend[DATA_W-1];
   assign sb_in_c = is_signed & divisor[DATA_W-1];

   // Next-state, datapath and output update logic.
   always_comb begin
      state_d = state_q;
      a_mag_d = a_mag_q;
      b_mag_d = b_mag_q;
      dvd_d   = dvd_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      dbz_d   = dbz_q;
      d_d     = d_q;
      r_d     = r_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      // busy stays up through the done cycle, then drops.
      if (done_q) busy_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && !busy_q) begin
               sa_d    = sa_in_c;
               sb_d    = sb_in_c;
               a_mag_d = sa_in_c ? (DATA_W'(0) - dividend) : dividend;
               b_mag_d = sb_in_c ? (DATA_W'(0) - divisor) : divisor;
               dvd_d   = dividend;
               dbz_d   = (divisor == '0);
               busy_d  = 1'b1;
               state_d = ST_PREP;
            end
         end
         ST_PREP: begin
            d_d   = (lz_c == LZ_W'(32)) ? '0 : (a_mag_q << lz_c);
            r_d   = '0;
            q_d   = '0;
            cnt_d = CNT_W'(32) - CNT_W'(lz_c);
            if (dbz_q || (lz_c == LZ_W'(32))) state_d = ST_FIX;
            else                              state_d = ST_ITER;
         end
         ST_ITER: begin
            if (ge_c) begin
               r_d = DATA_W'(t_c - {1'b0, b_mag_q});
               q_d = {q_q[DATA_W-2:0], 1'b1};
            end else begin
               r_d = t_c[DATA_W-1:0];
               q_d = {q_q[DATA_W-2:0], 1'b0};
            end
            d_d   = {d_q[DATA_W-2:0], 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
         end
         ST_FIX: begin
            if (dbz_q) begin
               quot_d = DBZ_QUOT;
               rem_d  = dvd_q;
            end else begin
               quot_d = (sa_q ^ sb_q) ? (DATA_W'(0) - q_q) : q_q;
               rem_d  = sa_q ? (DATA_W'(0) - r_q) : r_q;
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_mag_q <= '0;
         b_mag_q <= '0;
         dvd_q   <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         dbz_q   <= 1'b0;
         d_q     <= '0;
         r_q     <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_mag_q <= a_mag_d;
         b_mag_q <= b_mag_d;
         dvd_q   <= dvd_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         dbz_q   <= dbz_d;
         d_q     <= d_d;
         r_q     <= r_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign quotient  = quot_q;
   assign remainder = rem_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule : clz_divider

// File: tb/tb_clz_divider.sv
// Directed self-checking bench for clz_divider.
module tb_clz_divider;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] prev_q = 32'd0;

   clz_divider dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .is_signed (is_signed),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      int          lat;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // One operation: start at E0, optional stray start at edge inj, then check latency and results.
   task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input int lat,
                         input int inj, input string nm);
      int got;
      got = 0;
      is_signed = sgn;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = ~a;
      divisor  = ~b;
      chk({nm, " busy_after_E0"}, {31'd0, busy}, 32'd1);
      chk({nm, " quot_held"}, quotient, prev_q);
      for (int k = 1; k <= 60; k++) begin
         if (k == inj) begin
            start    = 1'b1;
            dividend = 32'd9;
            divisor  = 32'd3;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done) begin
            got = k;
            break;
         end
      end
      chk({nm, " latency"}, 32'(got), 32'(lat));
      chk({nm, " quotient"}, quotient, eq);
      chk({nm, " remainder"}, remainder, er);
      @(posedge clk);
      #1;
      chk({nm, " done_pulse"}, {31'd0, done}, 32'd0);
      chk({nm, " busy_low"}, {31'd0, busy}, 32'd0);
      prev_q = eq;
   endtask

   initial begin
      int ndone;
      vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          10};
      vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  6};
      vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          6};
      vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          35};
      vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          35};
      vecs[5]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          3};
      vecs[6]  = '{1'b0, 32'd0,          32'd9,          32'd0,          32'd0,          3};
      vecs[7]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  10};
      vecs[8]  = '{1'b1, 32'd5,          32'h8000_0000,  32'd0,          32'd5,          6};
      vecs[9]  = '{1'b0, 32'h1234_5678,  32'h0000_1000,  32'h0001_2345,  32'h0000_0678,  32};
      vecs[10] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  3};
      vecs[11] = '{1'b0, 32'd3,          32'd5,          32'd0,          32'd3,          5};
      vecs[12] = '{1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          35};

      rst_n     = 1'b0;
      start     = 1'b0;
      is_signed = 1'b0;
      dividend  = 32'd0;
      divisor   = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset quotient", quotient, 32'd0);
      chk("reset remainder", remainder, 32'd0);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 13; i++) begin
         run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].lat, 0,
                $sformatf("vec%0d", i));
      end

      // Stray start at E2 with other operands must be ignored.
      run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 10, 2, "ignore_start");

      // Reset at E5 of an operation aborts it with no later done.
      is_signed = 1'b0;
      dividend  = 32'd100;
      divisor   = 32'd7;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(posedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort done", {31'd0, done}, 32'd0);
      chk("abort quotient", quotient, 32'd0);
      chk("abort remainder", remainder, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      ndone = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      chk("abort no_done", 32'(ndone), 32'd0);
      prev_q = 32'd0;
      run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 7, 0, "after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_clz_divider
